// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header: strips the first s bytes of each AXI-Stream packet onto a header
// port and re-aligns the remaining payload MSB-first onto the output stream.
// Ports: clk/rst_n (async active-low); valid_in/data_in/keep_in/last_in/ready_in payload in;
// valid_extract/byte_extract_cnt/ready_extract per-packet header length; valid_header/
// data_header/keep_header/ready_header extracted header; valid_out/data_out/keep_out/last_out/
// ready_out re-aligned payload.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_extract,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    ready_extract,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);
  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [DATA_BYTE_WD-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;
  state_t state;
  logic [CW-1:0] s, kf, k, cfg_s, hm;
  logic [DATA_WD-1:0] prev;
  logic take, out_free, runt;
  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CW-1:0] n);
    return ~(ONES >> n);
  endfunction
  always_comb begin
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) k = k + CW'(keep_in[i]);
    cfg_s = (byte_extract_cnt == '0 || int'(byte_extract_cnt) >= DATA_BYTE_WD) ? CW'(1) : CW'(byte_extract_cnt);
    out_free = ~valid_out | ready_out;
    ready_in = ((state == FIRST && !valid_header) || state == BODY) && out_free;
    take = valid_in && ready_in;
    // a runt packet shrinks the header to the bytes actually received, kept LSB-aligned
    runt = last_in && k < s;
    hm = runt ? k : s;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready_extract <= 1'b0;
      s <= CW'(1);
      kf <= '0;
      prev <= '0;
      valid_header <= 1'b0;
      data_header <= '0;
      keep_header <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      keep_out <= '0;
      last_out <= 1'b0;
    end else begin
      if (valid_header && ready_header) valid_header <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;
      case (state)
        IDLE: begin
          ready_extract <= 1'b1;
          if (ready_extract && valid_extract) begin
            s <= cfg_s;
            ready_extract <= 1'b0;
            state <= FIRST;
          end
        end
        FIRST: if (take) begin
          valid_header <= 1'b1;
          data_header <= data_in >> (8 * (DATA_BYTE_WD - int'(hm)));
          keep_header <= ~(ONES << hm);
          prev <= data_in;
          if (!last_in) state <= BODY;
          else begin
            state <= IDLE;
            if (k > s) begin
              valid_out <= 1'b1;
              data_out <= data_in << (8 * int'(s));
              keep_out <= top_keep(k - s);
              last_out <= 1'b1;
            end
          end
        end
        BODY: if (take) begin
          prev <= data_in;
          valid_out <= 1'b1;
          data_out <= (prev << (8 * int'(s))) | (data_in >> (8 * (DATA_BYTE_WD - int'(s))));
          if (last_in && k <= s) begin
            keep_out <= top_keep(CW'(DATA_BYTE_WD) - s + k);
            last_out <= 1'b1;
            state <= IDLE;
          end else begin
            keep_out <= ONES;
            last_out <= 1'b0;
            if (last_in) begin
              kf <= k - s;
              state <= FLUSH;
            end
          end
        end
        FLUSH: if (out_free) begin
          valid_out <= 1'b1;
          data_out <= prev << (8 * int'(s));
          keep_out <= top_keep(kf);
          last_out <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb_axi_stream_extract_header: scoreboard bench; a byte-level packet model predicts header and
// payload beats, and a monitor pops and compares them on every output handshake.
module tb_axi_stream_extract_header;
  localparam int W = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic valid_in = 0, last_in = 0, ready_in, valid_extract = 0, ready_extract;
  logic [31:0] data_in = 0, data_header, data_out;
  logic [3:0] keep_in = 0, keep_header, keep_out;
  logic [1:0] byte_extract_cnt = 0;
  logic valid_header, ready_header = 1, valid_out, last_out, ready_out = 1;
  axi_stream_extract_header dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
    .last_in(last_in), .ready_in(ready_in), .valid_extract(valid_extract),
    .byte_extract_cnt(byte_extract_cnt), .ready_extract(ready_extract),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .ready_header(ready_header), .valid_out(valid_out), .data_out(data_out),
    .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out)
  );
  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  beat_t hdr_q[$], pay_q[$];
  byte unsigned pkt[$];
  int checks = 0, fails = 0;
  bit rnd_en = 0, mon_en = 1;
  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < W; i++) m[8*i+:8] = {8{k[i]}};
    return m;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Expected output from the packet bytes: first s bytes form the header, the rest is
  // repacked into W-byte beats, first byte most significant.
  task automatic model(input int s);
    int seff, len, m, pl;
    beat_t b;
    byte unsigned q[$];
    seff = (s == 0) ? 1 : s;
    len = pkt.size();
    m = (len < seff) ? len : seff;
    b.d = 0; b.l = 1;
    for (int i = 0; i < m; i++) b.d[8*(m-1-i)+:8] = pkt[i];
    b.k = 4'((1 << m) - 1);
    hdr_q.push_back(b);
    for (int i = seff; i < len; i++) q.push_back(pkt[i]);
    pl = q.size();
    for (int j = 0; j < pl; j += W) begin
      b.d = 0; b.k = 0;
      for (int bi = 0; bi < W; bi++)
        if (j + bi < pl) begin
          b.d[31-8*bi-:8] = q[j+bi];
          b.k[3-bi] = 1'b1;
        end
      b.l = (j + W >= pl);
      pay_q.push_back(b);
    end
  endtask
  task automatic cfg(input int s);
    bit hs;
    int n = 0;
    valid_extract = 1;
    byte_extract_cnt = 2'(s);
    do begin
      @(negedge clk);
      hs = ready_extract;
      tick();
      n++;
    end while (!hs && n < 1000);
    valid_extract = 0;
    if (!hs) chk("cfg_timeout", 0, 1);
  endtask
  task automatic send_beat(input int j, input bit last);
    bit hs;
    int n = 0, len = pkt.size();
    valid_in = 1;
    last_in = last;
    for (int bi = 0; bi < W; bi++) begin
      data_in[31-8*bi-:8] = (j*W + bi < len) ? pkt[j*W+bi] : 8'($urandom);
      keep_in[3-bi] = (j*W + bi < len);
    end
    do begin
      @(negedge clk);
      hs = ready_in;
      tick();
      n++;
    end while (!hs && n < 1000);
    valid_in = 0;
    last_in = 0;
    if (!hs) chk("beat_timeout", 0, 1);
  endtask
  task automatic send(input int s);
    int nb = (pkt.size() + W - 1) / W;
    model(s);
    cfg(s);
    for (int j = 0; j < nb; j++) begin
      while (rnd_en && $urandom_range(3) == 0) tick();
      send_beat(j, j == nb - 1);
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((hdr_q.size() != 0 || pay_q.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("drain", 32'(hdr_q.size() + pay_q.size()), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    ready_out = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
    ready_header = rnd_en ? ($urandom_range(2) != 0) : 1'b1;
  end
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && mon_en) begin
      if (valid_header && ready_header) begin
        if (hdr_q.size() == 0) chk("hdr_extra", 1, 0);
        else begin
          e = hdr_q.pop_front();
          chk("hdr_keep", 32'(keep_header), 32'(e.k));
          chk("hdr_data", data_header & bmask(e.k), e.d);
        end
      end
      if (valid_out && ready_out) begin
        if (pay_q.size() == 0) chk("pay_extra", 1, 0);
        else begin
          e = pay_q.pop_front();
          chk("pay_keep", 32'(keep_out), 32'(e.k));
          chk("pay_data", data_out & bmask(e.k), e.d);
          chk("pay_last", 32'(last_out), 32'(e.l));
        end
      end
    end
  end
  initial begin
    #2;
    chk("rst_ready_in", 32'(ready_in), 0);
    chk("rst_ready_extract", 32'(ready_extract), 0);
    chk("rst_valid_header", 32'(valid_header), 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_last_out", 32'(last_out), 0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(2);
    pkt = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(1);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send(3);
    pkt = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    send(1);
    pkt = '{8'hE1, 8'hE2};
    send(3);
    pkt = '{8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F};
    send(0);
    drain();
    rnd_en = 1;
    repeat (300) begin
      int len = $urandom_range(1, 64);
      pkt.delete();
      repeat (len) pkt.push_back(8'($urandom));
      send($urandom_range(1, 3));
    end
    drain();
    rnd_en = 0;
    tick();
    mon_en = 0;
    pkt.delete();
    repeat (12) pkt.push_back(8'($urandom));
    cfg(2);
    send_beat(0, 0);
    tick();
    rst_n = 0;
    #1;
    chk("mid_rst_valid_header", 32'(valid_header), 0);
    chk("mid_rst_valid_out", 32'(valid_out), 0);
    chk("mid_rst_ready_in", 32'(ready_in), 0);
    chk("mid_rst_ready_extract", 32'(ready_extract), 0);
    tick();
    rst_n = 1;
    mon_en = 1;
    pkt = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF};
    send(1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
